// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Parametrised pipeline stage register with a valid/ready
//               handshake, an optional skid entry, flush-to-bubble and
//               saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int                 WIDTH  = 64,
    parameter logic [WIDTH-1:0]   BUBBLE = '0,
    parameter bit                 SKID   = 1'b1,
    parameter int                 CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    // Held entries. The skid entry exists in both variants, but with SKID=0
    // the combinational in_ready never lets a payload reach it, so it stays
    // empty and is trimmed away by synthesis.
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [1:0]       occupancy_q,  occupancy_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

    logic w_accept;
    logic w_emit;

    assign w_accept = in_valid & in_ready;
    assign w_emit   = main_valid_q & out_ready;

    // in_ready source: registered skid-empty flag, or the classic
    // combinational "empty or draining" term for the single-entry variant.
    generate
        if (SKID) begin : g_skid
            assign in_ready = ~skid_valid_q;
        end else begin : g_no_skid
            assign in_ready = ~main_valid_q | out_ready;
        end
    endgenerate

    // Entry next-state: flush wins; otherwise load/hold/shift in FIFO order.
    // Invalid entries always carry BUBBLE so out_data is never X.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE;
        end else if (main_valid_q) begin
            if (w_emit) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data_q;
                    if (w_accept) begin
                        skid_data_d = in_data;
                    end else begin
                        skid_valid_d = 1'b0;
                        skid_data_d  = BUBBLE;
                    end
                end else if (w_accept) begin
                    main_data_d = in_data;
                end else begin
                    main_valid_d = 1'b0;
                    main_data_d  = BUBBLE;
                end
            end else if (w_accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (w_accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end
    end

    // Occupancy tracks the entries as they will be after this edge.
    always_comb begin
        occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    // Saturating counters; a flush cycle is never counted as a stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && !out_ready && !flush && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != C_CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers; reset overrides flush and every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= BUBBLE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= BUBBLE;
            occupancy_q  <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            occupancy_q  <= occupancy_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = occupancy_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Directed self-checking bench for pipe_stage_buf: a 64-bit
//               skid instance and an 8-bit single-entry instance with
//               4-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

    localparam logic [63:0] C_BUB_A = 64'hDEAD_BEEF_0000_0013;
    localparam logic [7:0]  C_BUB_B = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: WIDTH=64, SKID=1, CNT_W=16
    logic        a_rst, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall, a_fcnt;

    // instance B: WIDTH=8, SKID=0, CNT_W=4
    logic        b_rst, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_stall, b_fcnt;

    pipe_stage_buf #(.WIDTH(64), .BUBBLE(C_BUB_A), .SKID(1'b1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .occupancy(a_occ),
        .stall_cnt(a_stall), .flush_cnt(a_fcnt)
    );

    pipe_stage_buf #(.WIDTH(8), .BUBBLE(C_BUB_B), .SKID(1'b0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .occupancy(b_occ),
        .stall_cnt(b_stall), .flush_cnt(b_fcnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = 'x; a_flush = 1'b0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = 'x; b_flush = 1'b0; b_out_ready = 1'b0;
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;

        // reset state
        chk("rst_a_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_a_data",  a_out_data, C_BUB_A);
        chk("rst_a_occ",   {62'd0, a_occ}, 64'd0);
        chk("rst_a_ready", {63'd0, a_in_ready}, 64'd1);
        chk("rst_a_stall", {48'd0, a_stall}, 64'd0);
        chk("rst_a_fcnt",  {48'd0, a_fcnt}, 64'd0);
        chk("rst_b_data",  {56'd0, b_out_data}, {56'd0, C_BUB_B});

        // 1. streaming at full rate
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1; a_in_data = 64'(i);
            tick();
            chk("stream_valid", {63'd0, a_out_valid}, 64'd1);
            chk("stream_data",  a_out_data, 64'(i));
            chk("stream_ready", {63'd0, a_in_ready}, 64'd1);
        end
        a_in_valid = 1'b0; a_in_data = 'x;
        tick();
        chk("stream_end_valid", {63'd0, a_out_valid}, 64'd0);
        chk("stream_end_data",  a_out_data, C_BUB_A);
        chk("stream_stall",     {48'd0, a_stall}, 64'd0);

        // 2. backpressure into the skid entry
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'hA;
        tick();
        chk("bp_occ1",   {62'd0, a_occ}, 64'd1);
        chk("bp_ready1", {63'd0, a_in_ready}, 64'd1);
        a_in_data = 64'hB;
        tick();                                 // stall edge 1
        chk("bp_occ2",   {62'd0, a_occ}, 64'd2);
        chk("bp_ready2", {63'd0, a_in_ready}, 64'd0);
        chk("bp_hold",   a_out_data, 64'hA);
        a_in_valid = 1'b0; a_in_data = 'x;
        tick();                                 // stall edge 2
        chk("bp_hold2",  a_out_data, 64'hA);
        a_out_ready = 1'b1;
        tick();                                 // 0xA emitted
        chk("bp_emitB",  a_out_data, 64'hB);
        chk("bp_occ3",   {62'd0, a_occ}, 64'd1);
        chk("bp_ready3", {63'd0, a_in_ready}, 64'd1);
        tick();                                 // 0xB emitted
        chk("bp_empty",  {63'd0, a_out_valid}, 64'd0);
        chk("bp_occ0",   {62'd0, a_occ}, 64'd0);
        chk("bp_stall",  {48'd0, a_stall}, 64'd2);

        // 3. flush with both entries held and 0xC offered
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'hA;
        tick();
        a_in_data = 64'hB;
        tick();                                 // stall edge 3
        a_in_data = 64'hC; a_flush = 1'b1;
        tick();                                 // flush dominates the stall
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 'x;
        chk("fl_valid", {63'd0, a_out_valid}, 64'd0);
        chk("fl_data",  a_out_data, C_BUB_A);
        chk("fl_occ",   {62'd0, a_occ}, 64'd0);
        chk("fl_fcnt",  {48'd0, a_fcnt}, 64'd1);
        chk("fl_ready", {63'd0, a_in_ready}, 64'd1);
        chk("fl_stall", {48'd0, a_stall}, 64'd3);
        a_out_ready = 1'b1;
        tick();
        chk("fl_noC",   {63'd0, a_out_valid}, 64'd0);
        // accepted-while-flushing payload is discarded
        a_in_valid = 1'b1; a_in_data = 64'hD; a_flush = 1'b1;
        tick();
        a_in_valid = 1'b0; a_in_data = 'x; a_flush = 1'b0;
        chk("fl_acc_valid", {63'd0, a_out_valid}, 64'd0);
        chk("fl_fcnt2",     {48'd0, a_fcnt}, 64'd2);
        tick();
        chk("fl_noD",       {63'd0, a_out_valid}, 64'd0);

        // 4. reset mid-stream with flush asserted
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'h1;
        tick();
        a_in_data = 64'h2;
        tick();
        chk("mid_occ2", {62'd0, a_occ}, 64'd2);
        a_in_valid = 1'b0; a_in_data = 'x; a_rst = 1'b1; a_flush = 1'b1;
        tick();
        a_rst = 1'b0; a_flush = 1'b0;
        chk("mid_valid", {63'd0, a_out_valid}, 64'd0);
        chk("mid_data",  a_out_data, C_BUB_A);
        chk("mid_ready", {63'd0, a_in_ready}, 64'd1);
        chk("mid_occ",   {62'd0, a_occ}, 64'd0);
        chk("mid_stall", {48'd0, a_stall}, 64'd0);
        chk("mid_fcnt",  {48'd0, a_fcnt}, 64'd0);

        // 5. single-entry variant: combinational in_ready
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h11;
        tick();
        chk("s0_ready_lo", {63'd0, b_in_ready}, 64'd0);
        chk("s0_data11",   {56'd0, b_out_data}, 64'h11);
        b_out_ready = 1'b1;
        #1;
        chk("s0_ready_hi", {63'd0, b_in_ready}, 64'd1);
        b_in_data = 8'h22;
        tick();
        chk("s0_data22",   {56'd0, b_out_data}, 64'h22);
        b_in_data = 8'h33;
        tick();
        chk("s0_data33",   {56'd0, b_out_data}, 64'h33);
        chk("s0_occ",      {62'd0, b_occ}, 64'd1);
        b_in_valid = 1'b0; b_in_data = 'x;
        tick();
        chk("s0_empty",    {56'd0, b_out_data}, {56'd0, C_BUB_B});
        chk("s0_stall",    {60'd0, b_stall}, 64'd0);

        // 6. counter saturation
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h44;
        tick();
        b_in_valid = 1'b0; b_in_data = 'x;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_stall14", {60'd0, b_stall}, 64'd14);
        tick();
        chk("sat_stall15", {60'd0, b_stall}, 64'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_stall20", {60'd0, b_stall}, 64'd15);
        chk("sat_hold",    {56'd0, b_out_data}, 64'h44);
        b_flush = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("sat_fcnt15",  {60'd0, b_fcnt}, 64'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_fcnt20",  {60'd0, b_fcnt}, 64'd15);
        chk("sat_flvalid", {63'd0, b_out_valid}, 64'd0);
        b_flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
